// File: rtl/stream_capture_burst_pkg.sv
// stream_capture_pkg: writer FSM states, AXI burst/response constants and beat sizing helper
// shared by stream_capture_burst and its bench.
package stream_capture_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/stream_capture_burst_if.sv
// stream_capture_burst_if: AXI-Stream input plus AXI4 write-channel bundle; master is the capture
// engine side, slave is the stream source / memory side.
interface stream_capture_burst_if #(parameter int DATA_WIDTH = 512, ADDR_WIDTH = 34, ID_WIDTH = 6);
    localparam int BYTES = DATA_WIDTH / 8;
    logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [BYTES-1:0] s_axis_tkeep;
    logic m_axi_awvalid, m_axi_awready, m_axi_awlock;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0] m_axi_awlen;
    logic [ID_WIDTH-1:0] m_axi_awid;
    logic [2:0] m_axi_awsize, m_axi_awprot;
    logic [1:0] m_axi_awburst;
    logic [3:0] m_axi_awcache;
    logic m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [BYTES-1:0] m_axi_wstrb;
    logic m_axi_bvalid, m_axi_bready;
    logic [1:0] m_axi_bresp;
    modport master (
        input s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        output s_axis_tready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize, m_axi_awburst,
        output m_axi_awlock, m_axi_awcache, m_axi_awprot,
        input m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input m_axi_wready,
        input m_axi_bvalid, m_axi_bresp,
        output m_axi_bready
    );
    modport slave (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        input s_axis_tready,
        input m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize, m_axi_awburst,
        input m_axi_awlock, m_axi_awcache, m_axi_awprot,
        output m_axi_awready,
        input m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input m_axi_bready
    );
endinterface

// File: rtl/stream_capture_burst_fifo.sv
// capture_beat_fifo: synchronous first-word-fall-through beat FIFO with occupancy count.
module capture_beat_fifo #(parameter int WIDTH = 512, DEPTH = 32) (
    input  logic clk_stream,
    input  logic resetn_stream,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [$clog2(DEPTH):0] count,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    always_ff @(posedge clk_stream or negedge resetn_stream) begin
        if (!resetn_stream) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk_stream) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/stream_capture_burst.sv
// stream_capture_burst: captures stream beats into a memory ring with AXI4 INCR write bursts.
// Define STREAM_CAPTURE_PACK_EN to merge (header, tlast) beat pairs into single header-stripped beats.
module stream_capture_burst
    import stream_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH = 6,
    parameter int BURST_LEN = 4,
    parameter int FIFO_DEPTH = 32,
    parameter int HDR_BITS = 336
) (
    input  logic clk_stream,
    input  logic resetn_stream,
    stream_capture_burst_if.master bus,
    input  logic start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [31:0] ring_bytes,
    input  logic [31:0] capture_beats,
    output logic busy,
    output logic done,
    output logic err,
    output logic [31:0] beats_written
);
    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    logic start_q, start_rise, stop, full, push, pop, in_done, launch, s_hs;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0] ring, cap, in_cnt, offset, next_off;
    logic [CW-1:0] count;
    logic [7:0] bcnt;
    logic [DATA_WIDTH-1:0] push_data, fifo_dout;
    assign start_rise = start && !start_q && !busy;
    assign in_done = in_cnt == cap || stop;
    assign bus.s_axis_tready = busy && !full && !in_done;
    assign s_hs = bus.s_axis_tvalid && bus.s_axis_tready;
    assign pop = bus.m_axi_wvalid && bus.m_axi_wready;
    assign launch = busy && (count >= CW'(BURST_LEN) || (in_done && count != '0));
    assign next_off = offset + (32'(bus.m_axi_awlen) + 32'd1) * 32'(BYTES);
    assign bus.m_axi_wdata = state == DATA ? fifo_dout : '0;
    assign bus.m_axi_awid = '0;
    assign bus.m_axi_awsize = 3'($clog2(BYTES));
    assign bus.m_axi_awburst = BURST_INCR;
    assign bus.m_axi_awlock = 1'b0;
    assign bus.m_axi_awcache = '0;
    assign bus.m_axi_awprot = '0;
    assign bus.m_axi_wstrb = '1;
`ifdef STREAM_CAPTURE_PACK_EN
    logic [DATA_WIDTH-1:0] half;
    assign push = s_hs && bus.s_axis_tlast;
    assign push_data = (half >> HDR_BITS) | (bus.s_axis_tdata << (DATA_WIDTH - HDR_BITS));
    // half returns to zero after every pair so a lone tlast beat merges with an empty header beat
    always_ff @(posedge clk_stream or negedge resetn_stream) begin
        if (!resetn_stream) half <= '0;
        else if (start_rise) half <= '0;
        else if (s_hs) half <= bus.s_axis_tlast ? '0 : bus.s_axis_tdata;
    end
`else
    assign push = s_hs;
    assign push_data = bus.s_axis_tdata;
`endif
    capture_beat_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_stream(clk_stream), .resetn_stream(resetn_stream), .push(push), .pop(pop),
        .din(push_data), .dout(fifo_dout), .count(count), .full(full)
    );
    always_ff @(posedge clk_stream or negedge resetn_stream) begin
        if (!resetn_stream) begin
            state <= IDLE;
            {start_q, stop, busy, done, err} <= '0;
            {base, ring, cap, in_cnt, offset, beats_written, bcnt} <= '0;
            {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast, bus.m_axi_bready} <= '0;
            bus.m_axi_awaddr <= '0;
            bus.m_axi_awlen <= '0;
        end else begin
            start_q <= start;
            if (start_rise) begin
                {base, ring, cap} <= {start_addr, ring_bytes, capture_beats};
                {in_cnt, offset, beats_written} <= '0;
                {stop, done, err} <= '0;
                busy <= 1'b1;
            end else begin
                if (busy && !start) stop <= 1'b1;
                if (push) in_cnt <= in_cnt + 32'd1;
            end
            case (state)
                IDLE: if (launch) begin
                    state <= ADDR;
                    bus.m_axi_awvalid <= 1'b1;
                    bus.m_axi_awaddr <= base + ADDR_WIDTH'(offset);
                    bus.m_axi_awlen <= count >= CW'(BURST_LEN) ? 8'(BURST_LEN - 1) : 8'(count - 1'b1);
                end else if (busy && in_done && count == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                ADDR: if (bus.m_axi_awready) begin
                    state <= DATA;
                    bus.m_axi_awvalid <= 1'b0;
                    bus.m_axi_wvalid <= 1'b1;
                    bus.m_axi_wlast <= bus.m_axi_awlen == 8'd0;
                    bcnt <= '0;
                    offset <= next_off >= ring ? '0 : next_off;
                end
                DATA: if (pop) begin
                    beats_written <= beats_written + 32'd1;
                    bcnt <= bcnt + 8'd1;
                    bus.m_axi_wlast <= bcnt + 8'd1 == bus.m_axi_awlen;
                    if (bus.m_axi_wlast) begin
                        state <= RESP;
                        bus.m_axi_wvalid <= 1'b0;
                        bus.m_axi_bready <= 1'b1;
                    end
                end
                RESP: if (bus.m_axi_bvalid) begin
                    state <= IDLE;
                    bus.m_axi_bready <= 1'b0;
                    if (bus.m_axi_bresp != RESP_OKAY) err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
